sg_mem_wr_ctrl: RTL and testbench

SG_MEM_WR_CTRL -- requirements
Module: sg_mem_wr_ctrl

---
 rtl/sg_mem_wr_pkg.sv | 13 +
 rtl/sg_mem_wr_ctrl.sv | 108 ++++++++++
 tb/tb_sg_mem_wr_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sg_mem_wr_pkg.sv
// Shared types and default sizes for the scatter-gather waveform-memory write controller.
package sg_mem_wr_pkg;

  localparam int unsigned DEF_N = 10;
  localparam int unsigned DEF_B = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sg_mem_wr_ctrl.sv
// Streams AXI-S samples into waveform memory starting at start_addr, armed by a we rising edge.
// Optional status outputs (busy, wr_count) are built when SG_MEM_WR_STATUS_EN is defined.
module sg_mem_wr_ctrl
  import sg_mem_wr_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned B = DEF_B
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [31:0]  start_addr,
  input  logic         we,
  input  logic [B-1:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [B-1:0] mem_di
`ifdef SG_MEM_WR_STATUS_EN
  ,
  output logic         busy,
  output logic [N:0]   wr_count
`endif
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] WRITE = ST_WRITE;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic         we_q;
  logic         we_rise;
  logic         accept;
  logic         load;
  logic [N-1:0] addr_q;
  logic         unused_start_hi;

  assign unused_start_hi = ^start_addr[31:N];

  assign we_rise       = we & ~we_q;
  // Reset gating keeps tready low for the whole reset window, not just after the first edge.
  assign s_axis_tready = aresetn && (state_q == WRITE) && we;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign load          = (state_q == IDLE) && we_rise;

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (we_rise) state_d = WRITE;
      WRITE: begin
        if (!we)                         state_d = IDLE;
        else if (accept && s_axis_tlast) state_d = DONE;
      end
      DONE:    if (!we) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge detect, address counter and registered memory write port
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_di   <= '0;
    end else begin
      we_q   <= we;
      mem_we <= accept;
      if (load) begin
        addr_q <= start_addr[N-1:0];
      end else if (accept) begin
        addr_q <= addr_q + N'(1);
      end
      if (accept) begin
        mem_addr <= addr_q;
        mem_di   <= s_axis_tdata;
      end
    end
  end

`ifdef SG_MEM_WR_STATUS_EN
  // Status: busy mirrors WRITE, wr_count counts accepted beats of the current load, saturating
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      busy     <= 1'b0;
      wr_count <= '0;
    end else begin
      busy <= (state_d == WRITE);
      if (load) begin
        wr_count <= '0;
      end else if (accept && (wr_count != {(N+1){1'b1}})) begin
        wr_count <= wr_count + (N+1)'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sg_mem_wr_ctrl.sv
// Scoreboard bench for sg_mem_wr_ctrl: directed loads push expected writes, a monitor checks mem port.
module tb_sg_mem_wr_ctrl;

  localparam int unsigned N = 10;
  localparam int unsigned B = 32;

  typedef struct packed {
    logic [N-1:0] addr;
    logic [B-1:0] data;
  } exp_t;

  logic         aclk;
  logic         aresetn;
  logic [31:0]  start_addr;
  logic         we;
  logic [B-1:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [B-1:0] mem_di;
`ifdef SG_MEM_WR_STATUS_EN
  logic         busy;
  logic [N:0]   wr_count;
`endif

  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;

  sg_mem_wr_ctrl #(.N(N), .B(B)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start_addr    (start_addr),
    .we            (we),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_di        (mem_di)
`ifdef SG_MEM_WR_STATUS_EN
    ,
    .busy          (busy),
    .wr_count      (wr_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge aclk) begin
    if (mem_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_di);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_di !== e.data) begin
          n_fail++;
          $display("FAIL mem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   mem_addr, mem_di, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic start_load(input logic [31:0] a);
    start_addr = a;
    we         = 1'b1;
    tick();
    start_addr = 32'hFFFF_FFF0;
  endtask

  task automatic beat(input logic [B-1:0] d, input logic l, input logic [N-1:0] a);
    exp_t e;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic end_load();
    we = 1'b0;
    repeat (3) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    aresetn = 1'b0;
    we = 1'b0;
    start_addr = '0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (3) tick();
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_di", 64'(mem_di), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    aresetn = 1'b1;
    tick();
    chk("idle_tready", 64'(s_axis_tready), 64'd0);

    // Basic load at 0x10
    start_load(32'h0000_0010);
    chk("basic_tready", 64'(s_axis_tready), 64'd1);
`ifdef SG_MEM_WR_STATUS_EN
    chk("basic_busy", 64'(busy), 64'd1);
`endif
    beat(32'hD000_0000, 1'b0, 10'h010);
    beat(32'hD000_0001, 1'b0, 10'h011);
    beat(32'hD000_0002, 1'b0, 10'h012);
    beat(32'hD000_0003, 1'b1, 10'h013);
    chk("done_tready", 64'(s_axis_tready), 64'd0);
`ifdef SG_MEM_WR_STATUS_EN
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_wr_count", 64'(wr_count), 64'd4);
`endif
    end_load();

    // Address wrap
    start_load(32'h0000_03FE);
    beat(32'hA5A5_0001, 1'b0, 10'h3FE);
    beat(32'hA5A5_0002, 1'b0, 10'h3FF);
    beat(32'hA5A5_0003, 1'b1, 10'h000);
    end_load();

    // Source gap: tvalid 1,0,1,1
    start_load(32'h0000_0020);
    beat(32'h0000_1111, 1'b0, 10'h020);
    tick();
    chk("gap_mem_we", 64'(mem_we), 64'd0);
    beat(32'h0000_2222, 1'b0, 10'h021);
    beat(32'h0000_3333, 1'b1, 10'h022);
    end_load();

    // Abort after two of five beats
    start_load(32'h0000_0030);
    beat(32'hC0DE_0000, 1'b0, 10'h030);
    beat(32'hC0DE_0001, 1'b0, 10'h031);
    we = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hC0DE_0002;
    #1;
    chk("abort_tready", 64'(s_axis_tready), 64'd0);
    tick();
    s_axis_tdata = 32'hC0DE_0003;
    chk("abort_idle_tready", 64'(s_axis_tready), 64'd0);
    tick();
    s_axis_tvalid = 1'b0;
    end_load();

    // Re-arm: start_addr change while DONE is ignored, fresh we edge loads 0x40
    start_load(32'h0000_0050);
    beat(32'hE000_0050, 1'b1, 10'h050);
    start_addr = 32'h0000_0040;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD_BEEF;
    #1;
    chk("rearm_done_tready", 64'(s_axis_tready), 64'd0);
    repeat (2) tick();
    chk("rearm_done_tready2", 64'(s_axis_tready), 64'd0);
    s_axis_tvalid = 1'b0;
    we = 1'b0;
    tick();
    chk("rearm_idle_tready", 64'(s_axis_tready), 64'd0);
    start_load(32'h0000_0040);
`ifdef SG_MEM_WR_STATUS_EN
    chk("rearm_wr_count_clr", 64'(wr_count), 64'd0);
`endif
    beat(32'hE000_0040, 1'b1, 10'h040);
    end_load();

    // Reset mid-load
    start_load(32'h0000_0060);
    beat(32'hF000_0060, 1'b0, 10'h060);
    aresetn = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0BAD_0BAD;
    #1;
    chk("rstmid_tready", 64'(s_axis_tready), 64'd0);
    tick();
    chk("rstmid_mem_we", 64'(mem_we), 64'd0);
    chk("rstmid_mem_addr", 64'(mem_addr), 64'd0);
    chk("rstmid_mem_di", 64'(mem_di), 64'd0);
    chk("rstmid_tready2", 64'(s_axis_tready), 64'd0);
`ifdef SG_MEM_WR_STATUS_EN
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_wr_count", 64'(wr_count), 64'd0);
`endif
    s_axis_tvalid = 1'b0;
    we = 1'b0;
    aresetn = 1'b1;
    tick();
    chk("post_rst_tready", 64'(s_axis_tready), 64'd0);
    end_load();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
